// File: rtl/plic_pkg.sv
// Shared types and defaults for the PLIC interrupt gateway.
package plic_pkg;

    localparam int unsigned PLIC_NUM_SRC    = 128;
    localparam int unsigned PLIC_EDGE_CNT_W = 4;

    localparam logic PLIC_TRIG_LEVEL = 1'b0;
    localparam logic PLIC_TRIG_EDGE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_gw_src.sv
// Single-source interrupt gateway: optional input synchronizer (PLIC_GW_SYNC_EN),
// IDLE/REQ/WAIT handshake FSM and saturating pending-edge counter.
module plic_gw_src
    import plic_pkg::*;
#(
    parameter int unsigned EDGE_CNT_W = PLIC_EDGE_CNT_W,
    parameter bit          RESERVED   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic irq_src,
    input  logic src_type,
    input  logic int_end,
    output logic int_req,
    output logic in_service,
    output logic int_req_c
);

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = {EDGE_CNT_W{1'b1}};

    logic                  s;
    logic                  s_d;
    logic                  rise;
    logic                  is_edge;
    logic                  cnt_nz;
    logic                  trig;
    logic                  take;
    logic                  in_service_d;
    gw_state_e             state_q;
    gw_state_e             state_d;
    logic [EDGE_CNT_W-1:0] cnt_q;
    logic [EDGE_CNT_W-1:0] cnt_d;

`ifdef PLIC_GW_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for lines asynchronous to clk
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], irq_src};
        end
    end

    assign s = sync_q[1];
`else
    assign s = irq_src;
`endif

    assign rise    = s & ~s_d;
    assign is_edge = (src_type == PLIC_TRIG_EDGE);
    assign cnt_nz  = (cnt_q != '0);
    assign trig    = is_edge ? (rise | cnt_nz) : s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_d        <= 1'b0;
            int_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_d        <= s;
            int_req    <= int_req_c;
            in_service <= in_service_d;
        end
    end

    // Next state, pending-edge bookkeeping and next output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        take         = 1'b0;
        int_req_c    = 1'b0;
        in_service_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = REQ;
                    take    = 1'b1;
                end
            end
            REQ:     state_d = WAIT;
            WAIT:    if (int_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A rise that launches the request is consumed; otherwise it is queued.
        if (is_edge) begin
            if (rise && !take) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + EDGE_CNT_W'(1);
            end else if (take && !rise && cnt_nz) begin
                cnt_d = cnt_q - EDGE_CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (RESERVED) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        int_req_c    = (state_d == REQ);
        in_service_d = (state_d != IDLE);
    end

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway array: one plic_gw_src per source, source 0 reserved.
// Optional build macro PLIC_GW_SYNC_EN adds a 2-flop synchronizer per source.
module plic_gateway
    import plic_pkg::*;
#(
    parameter int unsigned NUM_SRC    = PLIC_NUM_SRC,
    parameter int unsigned EDGE_CNT_W = PLIC_EDGE_CNT_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] src_type,
    input  logic [NUM_SRC-1:0] int_end,
    output logic [NUM_SRC-1:0] int_req,
    output logic               gateway_notif,
    output logic [NUM_SRC-1:0] in_service
);

    localparam logic [NUM_SRC-1:0] SRC0_MASK = NUM_SRC'(1);

    logic [NUM_SRC-1:0] irq_gated;
    logic [NUM_SRC-1:0] end_gated;
    logic [NUM_SRC-1:0] req_c;

    // Source 0 never sees activity on its inputs
    assign irq_gated = irq_src & ~SRC0_MASK;
    assign end_gated = int_end & ~SRC0_MASK;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        plic_gw_src #(
            .EDGE_CNT_W (EDGE_CNT_W),
            .RESERVED   (n == 0)
        ) u_src (
            .clk        (clk),
            .rstn       (rstn),
            .irq_src    (irq_gated[n]),
            .src_type   (src_type[n]),
            .int_end    (end_gated[n]),
            .int_req    (int_req[n]),
            .in_service (in_service[n]),
            .int_req_c  (req_c[n])
        );
    end

    // Notification tracks the registered request vector cycle for cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gateway_notif <= 1'b0;
        end else begin
            gateway_notif <= |req_c;
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed self-checking bench for plic_gateway; inputs driven and outputs sampled on negedge.
module tb_plic_gateway;
    import plic_pkg::*;

    localparam int unsigned N = 128;
`ifdef PLIC_GW_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] irq_src;
    logic [N-1:0] src_type;
    logic [N-1:0] int_end;
    logic [N-1:0] int_req;
    logic [N-1:0] in_service;
    logic         gateway_notif;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    plic_gateway #(.NUM_SRC(N), .EDGE_CNT_W(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .irq_src       (irq_src),
        .src_type      (src_type),
        .int_end       (int_end),
        .int_req       (int_req),
        .gateway_notif (gateway_notif),
        .in_service    (in_service)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic count_req(input int n, input int cycles, output int req_n, output int notif_n);
        req_n   = 0;
        notif_n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (int_req[n] === 1'b1) req_n++;
            if (gateway_notif === 1'b1) notif_n++;
        end
    endtask

    task automatic complete(input int n);
        int_end[n] = 1'b1;
        tick();
        int_end[n] = 1'b0;
    endtask

    task automatic edge_pulse(input int n, inout int acc);
        irq_src[n] = 1'b1;
        tick();
        if (int_req[n] === 1'b1) acc++;
        irq_src[n] = 1'b0;
        tick();
        if (int_req[n] === 1'b1) acc++;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        irq_src  = '0;
        src_type = '0;
        int_end  = '0;
        repeat (2) tick();
        checks++; if (int_req !== '0) begin failures++; $display("FAIL reset_int_req got=%h exp=0", int_req); end
        checks++; if (gateway_notif !== 1'b0) begin failures++; $display("FAIL reset_notif got=%b exp=0", gateway_notif); end
        checks++; if (in_service !== '0) begin failures++; $display("FAIL reset_in_service got=%h exp=0", in_service); end
        rstn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_level();
        int lat;
        int r;
        int nt;
        bit found;
        lat   = 99;
        found = 1'b0;
        src_type[5] = PLIC_TRIG_LEVEL;
        irq_src[5]  = 1'b1;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (int_req[5] === 1'b1) begin
                found = 1'b1;
                lat   = i;
            end
        end
        checks++; if (lat !== LAT + 1) begin failures++; $display("FAIL level_latency got=%0d exp=%0d", lat, LAT + 1); end
        checks++; if (gateway_notif !== 1'b1) begin failures++; $display("FAIL level_notif got=%b exp=1", gateway_notif); end
        checks++; if (in_service[5] !== 1'b1) begin failures++; $display("FAIL level_in_service got=%b exp=1", in_service[5]); end
        count_req(5, 10, r, nt);
        checks++; if (r !== 0) begin failures++; $display("FAIL level_no_repeat got=%0d exp=0", r); end
        checks++; if (nt !== 0) begin failures++; $display("FAIL level_no_notif got=%0d exp=0", nt); end
        complete(5);
        checks++; if (in_service[5] !== 1'b0) begin failures++; $display("FAIL level_idle_after_end got=%b exp=0", in_service[5]); end
        checks++; if (int_req[5] !== 1'b0) begin failures++; $display("FAIL level_req_end_plus1 got=%b exp=0", int_req[5]); end
        tick();
        checks++; if (int_req[5] !== 1'b1) begin failures++; $display("FAIL level_rereq_end_plus2 got=%b exp=1", int_req[5]); end
        irq_src[5] = 1'b0;
        count_req(5, 5, r, nt);
        checks++; if (in_service[5] !== 1'b1) begin failures++; $display("FAIL level_drop_keeps_service got=%b exp=1", in_service[5]); end
        complete(5);
        tick();
        checks++; if (in_service[5] !== 1'b0) begin failures++; $display("FAIL level_final_idle got=%b exp=0", in_service[5]); end
    endtask

    task automatic test_edge_queue();
        int acc;
        int r;
        int nt;
        int exp_p[3];
        exp_p = '{1, 1, 0};
        acc = 0;
        src_type[40] = PLIC_TRIG_EDGE;
        repeat (3) edge_pulse(40, acc);
        count_req(40, LAT + 3, r, nt);
        acc += r;
        checks++; if (acc !== 1) begin failures++; $display("FAIL edge_first_req got=%0d exp=1", acc); end
        for (int k = 0; k < 3; k++) begin
            complete(40);
            count_req(40, 5, r, nt);
            checks++; if (r !== exp_p[k]) begin failures++; $display("FAIL edge_after_end%0d got=%0d exp=%0d", k, r, exp_p[k]); end
        end
        checks++; if (in_service[40] !== 1'b0) begin failures++; $display("FAIL edge_drained got=%b exp=0", in_service[40]); end
    endtask

    task automatic test_saturation();
        int acc;
        int r;
        int nt;
        int total;
        int last;
        acc  = 0;
        last = -1;
        edge_pulse(40, acc);
        count_req(40, LAT + 3, r, nt);
        acc += r;
        repeat (20) edge_pulse(40, acc);
        count_req(40, LAT + 3, r, nt);
        acc += r;
        checks++; if (acc !== 1) begin failures++; $display("FAIL sat_one_outstanding got=%0d exp=1", acc); end
        total = acc;
        for (int k = 0; k < 16; k++) begin
            complete(40);
            count_req(40, 5, r, nt);
            total += r;
            last = r;
        end
        checks++; if (total !== 16) begin failures++; $display("FAIL sat_total_reqs got=%0d exp=16", total); end
        checks++; if (last !== 0) begin failures++; $display("FAIL sat_last_end got=%0d exp=0", last); end
        checks++; if (in_service[40] !== 1'b0) begin failures++; $display("FAIL sat_drained got=%b exp=0", in_service[40]); end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_mask;
        exp_mask       = '0;
        exp_mask[1]    = 1'b1;
        exp_mask[33]   = 1'b1;
        exp_mask[65]   = 1'b1;
        exp_mask[127]  = 1'b1;
        irq_src = irq_src | exp_mask;
        repeat (LAT + 1) tick();
        checks++; if (int_req !== exp_mask) begin failures++; $display("FAIL simul_req got=%h exp=%h", int_req, exp_mask); end
        checks++; if (gateway_notif !== 1'b1) begin failures++; $display("FAIL simul_notif got=%b exp=1", gateway_notif); end
        tick();
        checks++; if (int_req !== '0) begin failures++; $display("FAIL simul_req_end got=%h exp=0", int_req); end
        checks++; if (gateway_notif !== 1'b0) begin failures++; $display("FAIL simul_notif_end got=%b exp=0", gateway_notif); end
        irq_src = irq_src & ~exp_mask;
        repeat (LAT + 2) tick();
        int_end = exp_mask;
        tick();
        int_end = '0;
        checks++; if (in_service !== '0) begin failures++; $display("FAIL simul_drained got=%h exp=0", in_service); end
    endtask

    task automatic test_reserved();
        int r;
        int nt;
        irq_src[0] = 1'b1;
        count_req(0, LAT + 6, r, nt);
        checks++; if (r !== 0) begin failures++; $display("FAIL rsvd_req got=%0d exp=0", r); end
        checks++; if (nt !== 0) begin failures++; $display("FAIL rsvd_notif got=%0d exp=0", nt); end
        checks++; if (in_service[0] !== 1'b0) begin failures++; $display("FAIL rsvd_in_service got=%b exp=0", in_service[0]); end
        irq_src[0] = 1'b0;
        complete(7);
        tick();
        checks++; if (in_service !== '0) begin failures++; $display("FAIL spurious_end_service got=%h exp=0", in_service); end
        checks++; if (int_req !== '0) begin failures++; $display("FAIL spurious_end_req got=%h exp=0", int_req); end
        irq_src[7] = 1'b1;
        repeat (LAT + 1) tick();
        checks++; if (int_req[7] !== 1'b1) begin failures++; $display("FAIL src7_normal_req got=%b exp=1", int_req[7]); end
        irq_src[7] = 1'b0;
        repeat (LAT + 2) tick();
        complete(7);
        checks++; if (in_service[7] !== 1'b0) begin failures++; $display("FAIL src7_drained got=%b exp=0", in_service[7]); end
    endtask

    task automatic test_reset_mid();
        int acc;
        int r;
        int nt;
        acc = 0;
        repeat (3) edge_pulse(40, acc);
        count_req(40, LAT + 3, r, nt);
        checks++; if (in_service[40] !== 1'b1) begin failures++; $display("FAIL rmid_pre_service got=%b exp=1", in_service[40]); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (in_service !== '0) begin failures++; $display("FAIL rmid_async_service got=%h exp=0", in_service); end
        checks++; if (int_req !== '0) begin failures++; $display("FAIL rmid_async_req got=%h exp=0", int_req); end
        checks++; if (gateway_notif !== 1'b0) begin failures++; $display("FAIL rmid_async_notif got=%b exp=0", gateway_notif); end
        tick();
        rstn = 1'b1;
        count_req(40, 20, r, nt);
        checks++; if (r !== 0) begin failures++; $display("FAIL rmid_no_req got=%0d exp=0", r); end
        checks++; if (nt !== 0) begin failures++; $display("FAIL rmid_no_notif got=%0d exp=0", nt); end
        checks++; if (in_service !== '0) begin failures++; $display("FAIL rmid_post_service got=%h exp=0", in_service); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_queue();
        test_saturation();
        test_simultaneous();
        test_reserved();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
